rf_file: RTL

Eight-entry, 8-bit register file for the CPU core, r0..r7. It receives the word chosen by the register-file input multiplexer on its single write port and serves two registered read ports to the ALU and memory-address logic. It also provides a continuous r0 tap back to the multiplexer. A per-register pending scoreboard tracks outstanding memory loads and stalls reads of a register whose load has not yet returned.

---
 rtl/cpu_common_pkg.sv | 16 +
 rtl/rf_scoreboard.sv | 36 +++
 rtl/rf_file.sv | 85 ++++++++
 3 files changed

// File: rtl/cpu_common_pkg.sv
// rtl/cpu_common_pkg.sv - shared CPU core types and constants
package cpu_common;

  localparam int RF_NUM_REGS = 8;
  localparam int RF_ADDR_W   = $clog2(RF_NUM_REGS);

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;

  typedef enum logic [1:0] {
    RF_SRC_ALU = 2'd0,
    RF_SRC_MEM = 2'd1,
    RF_SRC_IMM = 2'd2,
    RF_SRC_R0  = 2'd3
  } rf_in_sel_e;

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register pending-load bits with set-over-clear priority
module rf_scoreboard
  import cpu_common::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_en,
  input  logic [AW-1:0]       set_addr,
  input  logic                clr_en,
  input  logic [AW-1:0]       clr_addr,
  output logic [NUM_REGS-1:0] pending,
  output logic [NUM_REGS-1:0] pend_eff
);

  logic [NUM_REGS-1:0] pending_q, pending_d, clr_mask;

  // A returning load clears this cycle's view; a new load only affects later cycles.
  always_comb begin
    clr_mask = '0;
    if (clr_en) clr_mask[clr_addr] = 1'b1;
    pend_eff  = pending_q & ~clr_mask;
    pending_d = pend_eff;
    if (set_en) pending_d[set_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  assign pending = pending_q;

endmodule

// File: rtl/rf_file.sv
// rtl/rf_file.sv - register file with one write port, two registered read ports and load scoreboard
module rf_file
  import cpu_common::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int DATA_W   = 8,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [DATA_W-1:0]   rf_in,
  input  logic                wr_is_mem,
  input  logic                load_issue,
  input  logic [AW-1:0]       load_addr,
  input  logic                re_a,
  input  logic                re_b,
  input  logic [AW-1:0]       raddr_a,
  input  logic [AW-1:0]       raddr_b,
  output logic [DATA_W-1:0]   rdata_a,
  output logic [DATA_W-1:0]   rdata_b,
  output logic                rvalid_a,
  output logic                rvalid_b,
  output logic                stall,
  output logic [DATA_W-1:0]   r0,
  output logic [NUM_REGS-1:0] pending
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] pend_eff;
  logic [DATA_W-1:0]   fwd_a, fwd_b, rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
  logic                hit_a, hit_b, rvalid_a_q, rvalid_b_q;

  rf_scoreboard #(.NUM_REGS(NUM_REGS), .AW(AW)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (load_issue),
    .set_addr (load_addr),
    .clr_en   (we & wr_is_mem),
    .clr_addr (waddr),
    .pending  (pending),
    .pend_eff (pend_eff)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we) begin
      regs_q[waddr] <= rf_in;
    end
  end

  // Same-cycle write data is forwarded so a read never sees the stale word.
  always_comb begin
    fwd_a     = (we && (waddr == raddr_a)) ? rf_in : regs_q[raddr_a];
    fwd_b     = (we && (waddr == raddr_b)) ? rf_in : regs_q[raddr_b];
    hit_a     = re_a & ~pend_eff[raddr_a];
    hit_b     = re_b & ~pend_eff[raddr_b];
    rdata_a_d = hit_a ? fwd_a : rdata_a_q;
    rdata_b_d = hit_b ? fwd_b : rdata_b_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
    end else begin
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
      rvalid_a_q <= hit_a;
      rvalid_b_q <= hit_b;
    end
  end

  assign rdata_a  = rdata_a_q;
  assign rdata_b  = rdata_b_q;
  assign rvalid_a = rvalid_a_q;
  assign rvalid_b = rvalid_b_q;
  assign stall    = (re_a & pend_eff[raddr_a]) | (re_b & pend_eff[raddr_b]);
  assign r0       = regs_q[0];

endmodule
